serial_addsub_engine: RTL and testbench

- Parametrised bit-serial add/subtract engine. Successor to the fixed 8-bit serial adder datapath.
- Loads two WIDTH-bit operands on a start/ready handshake and processes one bit per clock, LSB first, through a single full-adder cell with a carry flop.
- Presents the parallel result with carry-out and a one-cycle done pulse.
- Sits between the operand register file and the result consumer; replaces the free-running shift/counter datapath.

---
 rtl/serial_pkg.sv | 9 +
 rtl/serial_fa_cell.sv | 29 ++
 rtl/serial_addsub_engine.sv | 100 ++++++++++
 tb/tb_serial_addsub_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and mode constants for the serial add/sub engine
package serial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: one full-adder bit slice with its carry flop; carry is the next-carry value
module serial_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    input  logic init,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry
);

    logic c_q;

    assign s     = a ^ b ^ c_q;
    assign carry = (a & b) | (a & c_q) | (b & c_q);

    // carry flop: seeded at operand load, advanced once per processed bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            c_q <= 1'b0;
        else if (load)
            c_q <= init;
        else if (en)
            c_q <= carry;
    end

endmodule

// File: rtl/serial_addsub_engine.sv
// serial_addsub_engine: bit-serial WIDTH-bit add/subtract, LSB first; SERIAL_OVF_EN adds signed overflow output ovf
module serial_addsub_engine
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [CNT_W-1:0] bit_cnt
`ifdef SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             s;
    logic             carry;
    logic             load;
    logic             en;

    assign load = (state == IDLE) && start;
    assign en   = (state == SHIFT);

    serial_fa_cell u_fa (
        .clk  (i_clk),
        .rst_n(reset),
        .load (load),
        .en   (en),
        .init (mode),
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .s    (s),
        .carry(carry)
    );

    // control FSM and datapath registers; subtract is a + ~b with carry seeded to 1
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            bit_cnt   <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
`ifdef SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg   <= a_in;
                    b_reg   <= (mode == MODE_SUB) ? ~b_in : b_in;
                    bit_cnt <= CNT_W'(WIDTH);
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    sum     <= {s, sum[WIDTH-1:1]};
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        carry_out <= carry;
`ifdef SERIAL_OVF_EN
                        // carry into MSB is recovered as s ^ a ^ b of the MSB slice
                        ovf       <= s ^ a_reg[0] ^ b_reg[0] ^ carry;
`endif
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_engine.sv
// tb_serial_addsub_engine: directed + random checks of WIDTH=8/16/2 engines against an arithmetic model
module tb_serial_addsub_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 8;
    logic        st = 1'b0;
    logic [31:0] av = '0;
    logic [31:0] bv = '0;
    logic        md = 1'b0;
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          dn = 0;

    always #5 clk = ~clk;

    logic        st8, st2, st16;
    logic        r8, r2, r16, bz8, bz2, bz16, d8, d2, d16, c8, c2, c16;
    logic [7:0]  s8;
    logic [1:0]  s2;
    logic [15:0] s16;
    logic [3:0]  n8;
    logic [1:0]  n2;
    logic [4:0]  n16;
    logic        v8, v2, v16;

    assign st8  = st && (sel == 8);
    assign st2  = st && (sel == 2);
    assign st16 = st && (sel == 16);

    serial_addsub_engine #(.WIDTH(8)) u8 (
        .i_clk(clk), .reset(rst_n), .start(st8), .mode(md), .a_in(av[7:0]), .b_in(bv[7:0]),
        .ready(r8), .busy(bz8), .done(d8), .sum(s8), .carry_out(c8), .bit_cnt(n8)
`ifdef SERIAL_OVF_EN
        , .ovf(v8)
`endif
    );

    serial_addsub_engine #(.WIDTH(2)) u2 (
        .i_clk(clk), .reset(rst_n), .start(st2), .mode(md), .a_in(av[1:0]), .b_in(bv[1:0]),
        .ready(r2), .busy(bz2), .done(d2), .sum(s2), .carry_out(c2), .bit_cnt(n2)
`ifdef SERIAL_OVF_EN
        , .ovf(v2)
`endif
    );

    serial_addsub_engine #(.WIDTH(16)) u16 (
        .i_clk(clk), .reset(rst_n), .start(st16), .mode(md), .a_in(av[15:0]), .b_in(bv[15:0]),
        .ready(r16), .busy(bz16), .done(d16), .sum(s16), .carry_out(c16), .bit_cnt(n16)
`ifdef SERIAL_OVF_EN
        , .ovf(v16)
`endif
    );

`ifndef SERIAL_OVF_EN
    assign v8  = 1'b0;
    assign v2  = 1'b0;
    assign v16 = 1'b0;
`endif

    logic [31:0] o_sum, o_bc;
    logic        o_rdy, o_busy, o_done, o_co, o_ovf;

    always_comb begin
        o_sum  = sel == 2 ? 32'(s2)  : sel == 16 ? 32'(s16) : 32'(s8);
        o_bc   = sel == 2 ? 32'(n2)  : sel == 16 ? 32'(n16) : 32'(n8);
        o_rdy  = sel == 2 ? r2  : sel == 16 ? r16  : r8;
        o_busy = sel == 2 ? bz2 : sel == 16 ? bz16 : bz8;
        o_done = sel == 2 ? d2  : sel == 16 ? d16  : d8;
        o_co   = sel == 2 ? c2  : sel == 16 ? c16  : c8;
        o_ovf  = sel == 2 ? v2  : sel == 16 ? v16  : v8;
    end

    always @(posedge clk) begin
        cyc++;
        if (o_done) dn++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // (w+1)-bit unsigned sum for carry/result, signed range test for overflow
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                         output logic [31:0] es, output logic eco, output logic eov);
        longint mask = (64'd1 << w) - 1;
        longint half = 64'd1 << (w - 1);
        longint la = longint'(a) & mask;
        longint lb = longint'(b) & mask;
        longint full = la + (m ? ((~lb & mask) + 1) : lb);
        longint sa = la >= half ? la - 2 * half : la;
        longint sb = lb >= half ? lb - 2 * half : lb;
        longint r = m ? sa - sb : sa + sb;
        es  = 32'(full & mask);
        eco = ((full >> w) & 1) != 0;
        eov = (r < -half) || (r > half - 1);
    endtask

    // caller is at a negedge with the selected engine idle
    task automatic run(input int w, input logic [31:0] a, input logic [31:0] b, input logic m);
        logic [31:0] es;
        logic eco, eov;
        int lat;
        model(w, a, b, m, es, eco, eov);
        sel = w; av = a; bv = b; md = m; st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0; av = $urandom; bv = $urandom; md = 1'(($urandom));
        chk("busy_in_shift", {31'd0, o_busy}, 32'd1);
        chk("ready_in_shift", {31'd0, o_rdy}, 32'd0);
        lat = 1;
        while (!o_done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("latency_w%0d", w), lat, w + 1);
        chk($sformatf("sum_w%0d_%0h_%0h_%0d", w, a, b, m), o_sum, es);
        chk("carry_out", {31'd0, o_co}, {31'd0, eco});
`ifdef SERIAL_OVF_EN
        chk("ovf", {31'd0, o_ovf}, {31'd0, eov});
`endif
        @(negedge clk);
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        chk("ready_after", {31'd0, o_rdy}, 32'd1);
        chk("sum_held", o_sum, es);
    endtask

    initial begin
        logic [31:0] es, ta, tb_, tm;
        logic eco, eov;
        int d0, k, t_last, nd;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, r8}, 32'd1);
        chk("rst_busy", {31'd0, bz8}, 32'd0);
        chk("rst_done", {31'd0, d8}, 32'd0);
        chk("rst_sum", {24'd0, s8}, 32'd0);
        chk("rst_bitcnt", {28'd0, n8}, 32'd0);
        chk("rst_co", {31'd0, c8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(8, 32'h5A, 32'h3C, 1'b0);
        chk("add_5a_3c", o_sum, 32'h96);
        run(8, 32'hFF, 32'h01, 1'b0);
        chk("wrap_ff_01_co", {31'd0, o_co}, 32'd1);
        run(8, 32'h10, 32'h20, 1'b1);
        chk("sub_10_20", o_sum, 32'hF0);
        run(8, 32'h80, 32'h01, 1'b1);
        chk("sub_80_01", o_sum, 32'h7F);
        run(8, 32'h00, 32'h00, 1'b1);
        chk("sub_0_0_co", {31'd0, o_co}, 32'd1);

        // start pulsed in SHIFT and in DONE must be ignored
        d0 = dn;
        sel = 8; av = 32'h11; bv = 32'h22; md = 1'b0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (3) @(negedge clk);
        av = 32'hAA; bv = 32'hAA; md = 1'b1; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        k = 0;
        while (!o_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("hs_sum", o_sum, 32'h33);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        chk("hs_ready", {31'd0, o_rdy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("hs_busy", {31'd0, o_busy}, 32'd0);
        chk("hs_single_done", dn - d0, 1);
        chk("hs_sum_held", o_sum, 32'h33);

        // start held high: back-to-back every WIDTH+2 cycles
        ta = $urandom & 32'hFF; tb_ = $urandom & 32'hFF; tm = $urandom & 1;
        model(8, ta, tb_, tm[0], es, eco, eov);
        av = ta; bv = tb_; md = tm[0]; st = 1'b1;
        nd = 0; k = 0; t_last = 0;
        while (nd < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (o_done) begin
                if (nd == 2) st = 1'b0;
                chk("b2b_sum", o_sum, es);
                chk("b2b_co", {31'd0, o_co}, {31'd0, eco});
                if (nd > 0) chk("b2b_period", cyc - t_last, 10);
                t_last = cyc;
                nd++;
            end
        end
        chk("b2b_count", nd, 3);
        st = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset mid-operation
        av = 32'h0F; bv = 32'h01; md = 1'b0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        k = 0;
        while (o_bc != 4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("mid_bitcnt4", o_bc, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", o_sum, 32'h0);
        chk("mid_rst_bc", o_bc, 32'h0);
        chk("mid_rst_co", {31'd0, o_co}, 32'd0);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_rdy}, 32'd1);
        d0 = dn;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", dn - d0, 0);
        run(8, 32'h01, 32'h01, 1'b0);
        chk("post_rst_add", o_sum, 32'h02);

        for (int i = 0; i < 20; i++) run(8, $urandom, $urandom, 1'(($urandom)));

        run(16, 32'hFFFF, 32'h0001, 1'b0);
        chk("w16_sum", o_sum, 32'h0);
        chk("w16_co", {31'd0, o_co}, 32'd1);
        for (int i = 0; i < 5; i++) run(16, $urandom, $urandom, 1'(($urandom)));

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int m = 0; m < 2; m++)
                    run(2, a, b, m[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
